// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed FIR controller: one shared signed MAC walks TAPS taps
// per accepted sample, owning sample history, coefficients and accumulator.
module fir_mac_scheduler #(
    parameter int TAPS     = 20,
    parameter int BIT_PREC = 8,
    parameter int OUT_SIZE = 2*BIT_PREC + $clog2(TAPS-1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       coef_wr,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic [BIT_PREC-1:0]        coef_data,
    input  logic                       hist_clr,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [BIT_PREC-1:0]        s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [OUT_SIZE-1:0]        m_data,
    output logic                       busy
);

    localparam int AW = $clog2(TAPS);
    localparam logic [AW-1:0] LAST   = AW'(TAPS-1);
    localparam logic [AW:0]   TAPS_X = (AW+1)'(TAPS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]                  state_q, state_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]               tap_cnt_q, tap_cnt_d;
    logic [AW-1:0]               rd_idx;
    logic signed [OUT_SIZE-1:0]  acc_q, acc_d;
    logic signed [OUT_SIZE-1:0]  m_data_q, m_data_d;
    logic signed [OUT_SIZE-1:0]  prod_ext, acc_sum;
    logic signed [2*BIT_PREC-1:0] prod;
    logic signed [BIT_PREC-1:0]  hist_q [TAPS];
    logic signed [BIT_PREC-1:0]  hist_d [TAPS];
    logic signed [BIT_PREC-1:0]  coef_q [TAPS];
    logic signed [BIT_PREC-1:0]  coef_d [TAPS];

    assign s_ready = rst_n && (state_q == S_IDLE) && !coef_wr && !hist_clr;
    assign m_valid = (state_q == S_OUT);
    assign m_data  = m_data_q;
    assign busy    = (state_q != S_IDLE);

    // x[n-k] lives at (wr_ptr - k) mod TAPS; no power-of-two assumption
    always_comb begin
        rd_idx = wr_ptr_q - tap_cnt_q;
        if (tap_cnt_q > wr_ptr_q) begin
            rd_idx = AW'(({1'b0, wr_ptr_q} + TAPS_X) - {1'b0, tap_cnt_q});
        end
    end

    assign prod     = coef_q[tap_cnt_q] * hist_q[rd_idx];
    assign prod_ext = OUT_SIZE'(prod);
    assign acc_sum  = acc_q + prod_ext;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        tap_cnt_d = tap_cnt_q;
        acc_d     = acc_q;
        m_data_d  = m_data_q;
        hist_d    = hist_q;
        coef_d    = coef_q;
        unique case (state_q)
            S_IDLE: begin
                if (coef_wr) begin
                    if (coef_addr <= LAST) begin
                        coef_d[coef_addr] = coef_data;
                    end
                end else if (hist_clr) begin
                    for (int i = 0; i < TAPS; i++) begin
                        hist_d[i] = '0;
                    end
                    wr_ptr_d = '0;
                end else if (s_valid && s_ready) begin
                    hist_d[wr_ptr_q] = s_data;
                    acc_d     = '0;
                    tap_cnt_d = '0;
                    state_d   = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_sum;
                if (tap_cnt_q == LAST) begin
                    wr_ptr_d  = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
                    tap_cnt_d = '0;
                    m_data_d  = acc_sum;
                    state_d   = S_OUT;
                end else begin
                    tap_cnt_d = tap_cnt_q + 1'b1;
                end
            end
            S_OUT: begin
                if (m_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            tap_cnt_q <= '0;
            acc_q     <= '0;
            m_data_q  <= '0;
            for (int i = 0; i < TAPS; i++) begin
                hist_q[i] <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            tap_cnt_q <= tap_cnt_d;
            acc_q     <= acc_d;
            m_data_q  <= m_data_d;
            hist_q    <= hist_d;
            coef_q    <= coef_d;
        end
    end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Scoreboard bench for fir_mac_scheduler: stimulus pushes expected results,
// a monitor pops and compares on every output handshake.
module tb_fir_mac_scheduler;

    localparam int TAPS = 20;
    localparam int BP   = 8;
    localparam int OS   = 2*BP + $clog2(TAPS-1);
    localparam int AW   = $clog2(TAPS);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 coef_wr;
    logic [AW-1:0]        coef_addr;
    logic [BP-1:0]        coef_data;
    logic                 hist_clr;
    logic                 s_valid;
    logic                 s_ready;
    logic [BP-1:0]        s_data;
    logic                 m_valid;
    logic                 m_ready;
    logic signed [OS-1:0] m_data;
    logic                 busy;

    int    checks = 0;
    int    errors = 0;
    longint sb[$];

    fir_mac_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .coef_wr   (coef_wr),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .hist_clr  (hist_clr),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: a transfer happens at the next rising edge
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", longint'(m_data), -1);
            end else begin
                check("y", longint'(m_data), sb.pop_front());
            end
        end
    end

    function automatic int xr(input int n);
        return n*3 - 60;
    endfunction

    task automatic write_coef(input int k, input int v);
        coef_wr   = 1'b1;
        coef_addr = AW'(k);
        coef_data = BP'(v);
        @(posedge clk); #1;
        coef_wr = 1'b0;
    endtask

    task automatic clr_hist();
        hist_clr = 1'b1;
        @(posedge clk); #1;
        hist_clr = 1'b0;
    endtask

    task automatic send_sample(input int x);
        bit ok = 1'b0;
        s_valid = 1'b1;
        s_data  = BP'(x);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        @(negedge clk);
        while (!m_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!m_valid) check("valid_timeout", 0, 1);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; coef_wr = 1'b0; coef_addr = '0; coef_data = '0;
        hist_clr = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        @(negedge clk);
        check("s_ready_in_reset", s_ready, 0);
        @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", longint'(m_data), 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_s_ready", s_ready, 1);
        @(posedge clk); #1;

        // impulse response
        for (int k = 0; k < TAPS; k++) write_coef(k, k+1);
        for (int n = 0; n < TAPS; n++) begin
            sb.push_back(127*(n+1));
            send_sample(n == 0 ? 127 : 0);
        end
        sb.push_back(0);
        send_sample(0);
        drain();

        // largest magnitude products
        clr_hist();
        for (int k = 0; k < TAPS; k++) write_coef(k, -128);
        for (int n = 0; n < TAPS; n++) begin
            sb.push_back(16384*(n+1));
            send_sample(-128);
        end
        drain();

        // history pointer wraps twice
        clr_hist();
        for (int k = 0; k < TAPS; k++) write_coef(k, (k == 0 || k == TAPS-1) ? 1 : 0);
        for (int n = 0; n < 45; n++) begin
            sb.push_back(xr(n) + (n >= TAPS-1 ? xr(n-(TAPS-1)) : 0));
            send_sample(xr(n));
        end
        drain();

        // backpressure with a pending sample
        m_ready = 1'b0;
        sb.push_back(93);
        send_sample(xr(45));
        wait_valid(lat);
        check("latency", lat, TAPS);
        @(posedge clk); #1;
        s_valid = 1'b1;
        s_data  = BP'(xr(46));
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("bp_m_valid", m_valid, 1);
            check("bp_m_data", longint'(m_data), 93);
            check("bp_s_ready", s_ready, 0);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        sb.push_back(99);
        send_sample(xr(46));
        drain();

        // writes while busy are ignored
        sb.push_back(105);
        send_sample(xr(47));
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        coef_wr = 1'b1; coef_addr = '0; coef_data = 8'd5;
        @(negedge clk);
        check("mac_s_ready", s_ready, 0);
        @(posedge clk); #1;
        coef_wr = 1'b0;
        wait_valid(lat);
        @(posedge clk); #1;
        hist_clr = 1'b1;
        @(negedge clk);
        check("out_hold_valid", m_valid, 1);
        @(posedge clk); #1;
        hist_clr = 1'b0;
        m_ready = 1'b1;
        sb.push_back(111);
        send_sample(xr(48));
        drain();

        // reset during tap 7
        send_sample(50);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_s_ready", s_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_m_data", longint'(m_data), 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_s_ready_idle", s_ready, 1);
        @(posedge clk); #1;
        sb.push_back(0);
        send_sample(127);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
